// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared pipeline control-word fields, writeback selects and load funct3 codes
package wb_regfile_pkg;

    // Bit positions inside the 32-bit WB control word
    localparam int CTL_REG_WE    = 0;
    localparam int CTL_WB_SEL_LO = 1;
    localparam int CTL_WB_SEL_HI = 2;
    localparam int CTL_VALID     = 3;

    // Writeback source select encodings
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_ALU2 = 2'b11;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - byte/halfword lane select and sign/zero extension of a loaded word
module load_ext
    import wb_regfile_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte lane and halfword lane; lw and unknown codes pass the word through
    always_comb begin
        byte_sel = word[8*addr +: 8];
        half_sel = addr[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LW:   value = word;
            F3_LBU:  value = {24'd0, byte_sel};
            F3_LHU:  value = {16'd0, half_sel};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage: result select, x1..x31 register array, bypassed reads, retire counter
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      ctl_WB,
    input  logic [31:0]      ir_WB,
    input  logic [31:0]      ra_WB,
    input  logic [31:0]      rdata_WB,
    input  logic [31:0]      alu_y_WB,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [31:0]      rs1_data,
    output logic [31:0]      rs2_data,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic [CNT_W-1:0] retire_cnt
);

    // x0 is hardwired, so storage starts at x1
    logic [31:0]      regs_q [1:NREG-1];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic        valid;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [31:0] load_val;

    logic unused_bits;
    assign unused_bits = ^{ctl_WB[31:4], ir_WB[31:15], ir_WB[6:0]};

    assign valid  = ctl_WB[CTL_VALID];
    assign reg_we = ctl_WB[CTL_REG_WE];
    assign wb_sel = ctl_WB[CTL_WB_SEL_HI:CTL_WB_SEL_LO];
    assign wb_rd  = ir_WB[11:7];
    assign funct3 = ir_WB[14:12];

    load_ext u_load_ext (
        .word   (rdata_WB),
        .addr   (alu_y_WB[1:0]),
        .funct3 (funct3),
        .value  (load_val)
    );

    // Writeback source mux and the qualified write enable seen by forwarding
    always_comb begin
        case (wb_sel)
            WB_SEL_LOAD: wb_data = load_val;
            WB_SEL_LINK: wb_data = ra_WB;
            default:     wb_data = alu_y_WB;
        endcase
        wb_we = valid && reg_we && (wb_rd != 5'd0);
    end

    // Read port: x0 always zero, then write-first bypass, then the array
    function automatic logic [31:0] read_port(input logic [4:0] a);
        if (a == 5'd0)
            return 32'd0;
        if (wb_we && (a == wb_rd))
            return wb_data;
        if (int'(a) < NREG)
            return regs_q[a];
        return 32'd0;
    endfunction

    assign rs1_data = read_port(rs1_addr);
    assign rs2_data = read_port(rs2_addr);
    assign dbg_data = read_port(dbg_addr);

    // Register array: cleared by reset, one register written per qualified writeback
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 1; i < NREG; i++)
                regs_q[i] <= 32'd0;
        end else if (wb_we && (int'(wb_rd) < NREG)) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // Every valid instruction retires, whether or not it writes a register; wraps silently
    assign cnt_d = valid ? cnt_q + 1'b1 : cnt_q;

    // Retire counter state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic [31:0]      ctl_WB, ir_WB, ra_WB, rdata_WB, alu_y_WB;
    logic [4:0]       rs1_addr, rs2_addr, dbg_addr;
    logic [31:0]      rs1_data, rs2_data, dbg_data;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic [CNT_W-1:0] retire_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    wb_regfile #(.NREG(32), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ctl_WB     (ctl_WB),
        .ir_WB      (ir_WB),
        .ra_WB      (ra_WB),
        .rdata_WB   (rdata_WB),
        .alu_y_WB   (alu_y_WB),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk_ctl(input logic v, input logic we, input logic [1:0] sel);
        return {28'd0, v, sel, we};
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] rd, input logic [2:0] f3);
        return {17'd0, f3, rd, 7'b0110011};
    endfunction

    // Present one writeback-stage operation at the falling edge
    task automatic drive(input logic v, input logic we, input logic [1:0] sel,
                         input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] y);
        @(negedge clk);
        ctl_WB   = mk_ctl(v, we, sel);
        ir_WB    = mk_ir(rd, f3);
        alu_y_WB = y;
        #1;
    endtask

    // Combinational load-extension vector, presented as a bubble so no state changes
    task automatic load_vec(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                            input logic [31:0] exp);
        ctl_WB   = mk_ctl(1'b0, 1'b1, 2'b01);
        ir_WB    = mk_ir(5'd1, f3);
        alu_y_WB = {30'h0000_1000, lo};
        #1;
        check(tag, wb_data, exp);
    endtask

    initial begin
        rstn = 1'b0;
        ctl_WB = '0; ir_WB = '0; ra_WB = 32'h0000_0104; rdata_WB = '0; alu_y_WB = '0;
        rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;

        // Reset state: every address reads zero on all three ports
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a); rs2_addr = 5'(31 - a); dbg_addr = 5'(a);
            #1;
            check($sformatf("rst_rs1_x%0d", a), rs1_data, 32'd0);
            check($sformatf("rst_rs2_x%0d", 31 - a), rs2_data, 32'd0);
            check($sformatf("rst_dbg_x%0d", a), dbg_data, 32'd0);
        end
        check("rst_cnt", 32'(retire_cnt), 32'd0);

        // Write x5 with same-cycle bypass, then read back from the array
        rs1_addr = 5'd5;
        drive(1'b1, 1'b1, 2'b00, 5'd5, 3'b000, 32'h1234_5678);
        check("x5_bypass", rs1_data, 32'h1234_5678);
        check("x5_we", 32'(wb_we), 32'd1);
        check("x5_rd", 32'(wb_rd), 32'd5);
        drive(1'b0, 1'b0, 2'b00, 5'd0, 3'b000, 32'h0);
        check("x5_array", rs1_data, 32'h1234_5678);
        check("cnt_after_x5", 32'(retire_cnt), 32'd1);

        // Load extension against rdata 0x8091_A2B3
        rdata_WB = 32'h8091_A2B3;
        load_vec("lb_01",    3'b000, 2'b01, 32'hFFFF_FFA2);
        load_vec("lbu_01",   3'b100, 2'b01, 32'h0000_00A2);
        load_vec("lh_hi",    3'b001, 2'b10, 32'hFFFF_8091);
        load_vec("lhu_hi",   3'b101, 2'b10, 32'h0000_8091);
        load_vec("lb_00",    3'b000, 2'b00, 32'hFFFF_FFB3);
        load_vec("lbu_11",   3'b100, 2'b11, 32'h0000_0080);
        load_vec("lhu_lo",   3'b101, 2'b00, 32'h0000_A2B3);
        load_vec("lh_lo",    3'b001, 2'b01, 32'hFFFF_A2B3);
        load_vec("lw_01",    3'b010, 2'b01, 32'h8091_A2B3);
        load_vec("f3_011",   3'b011, 2'b10, 32'h8091_A2B3);
        load_vec("f3_111",   3'b111, 2'b11, 32'h8091_A2B3);
        check("load_bubble_we", 32'(wb_we), 32'd0);

        // Link and alternate ALU selects
        ctl_WB = mk_ctl(1'b0, 1'b1, 2'b10); alu_y_WB = 32'h0000_5555; #1;
        check("sel_link", wb_data, 32'h0000_0104);
        ctl_WB = mk_ctl(1'b0, 1'b1, 2'b11); #1;
        check("sel_alu2", wb_data, 32'h0000_5555);
        check("cnt_after_loads", 32'(retire_cnt), 32'd1);

        // Write to x0 is discarded but still retires
        rs1_addr = 5'd0;
        drive(1'b1, 1'b1, 2'b00, 5'd0, 3'b000, 32'hDEAD_BEEF);
        check("x0_we", 32'(wb_we), 32'd0);
        check("x0_read", rs1_data, 32'd0);
        @(posedge clk); #1;
        check("x0_after", rs1_data, 32'd0);
        check("cnt_after_x0", 32'(retire_cnt), 32'd2);

        // Write x3 with bypass on rs2 and debug port, then a bubble aimed at x3
        rs2_addr = 5'd3; dbg_addr = 5'd3;
        drive(1'b1, 1'b1, 2'b00, 5'd3, 3'b000, 32'hAAAA_0003);
        check("x3_rs2_bypass", rs2_data, 32'hAAAA_0003);
        check("x3_dbg_bypass", dbg_data, 32'hAAAA_0003);
        drive(1'b0, 1'b1, 2'b00, 5'd3, 3'b000, 32'h0000_0055);
        check("bubble_we", 32'(wb_we), 32'd0);
        check("bubble_wb_rd", 32'(wb_rd), 32'd3);
        check("bubble_wb_data", wb_data, 32'h0000_0055);
        check("bubble_no_bypass", dbg_data, 32'hAAAA_0003);
        @(posedge clk); #1;
        check("x3_kept", dbg_data, 32'hAAAA_0003);
        check("cnt_after_bubble", 32'(retire_cnt), 32'd3);
        check("x5_kept", rs1_data, 32'd0);
        rs1_addr = 5'd5; #1;
        check("x5_still", rs1_data, 32'h1234_5678);

        // Retire counter wrap at 2^CNT_W-1
        for (int k = 0; k < 12; k++)
            drive(1'b1, 1'b0, 2'b00, 5'd4, 3'b000, 32'h0);
        drive(1'b0, 1'b0, 2'b00, 5'd0, 3'b000, 32'h0);
        check("cnt_max", 32'(retire_cnt), 32'd15);
        drive(1'b1, 1'b0, 2'b00, 5'd4, 3'b000, 32'h0);
        drive(1'b0, 1'b0, 2'b00, 5'd0, 3'b000, 32'h0);
        check("cnt_wrap", 32'(retire_cnt), 32'd0);
        dbg_addr = 5'd4; #1;
        check("x4_unwritten", dbg_data, 32'd0);

        // Asynchronous reset between edges after writing x7
        dbg_addr = 5'd7;
        drive(1'b1, 1'b1, 2'b00, 5'd7, 3'b000, 32'h0000_0777);
        drive(1'b0, 1'b0, 2'b00, 5'd0, 3'b000, 32'h0);
        check("x7_written", dbg_data, 32'h0000_0777);
        check("cnt_before_rst", 32'(retire_cnt), 32'd1);
        #1 rstn = 1'b0;
        #1;
        check("x7_async_rst", dbg_data, 32'd0);
        check("cnt_async_rst", 32'(retire_cnt), 32'd0);
        check("x5_async_rst", rs1_data, 32'd0);

        // Pending valid write held across reset commits on the first edge after release
        ctl_WB = mk_ctl(1'b1, 1'b1, 2'b00); ir_WB = mk_ir(5'd9, 3'b000); alu_y_WB = 32'h0000_0999;
        @(posedge clk); #1;
        dbg_addr = 5'd9; ctl_WB = '0; #1;
        check("x9_no_write_in_rst", dbg_data, 32'd0);
        check("cnt_held_in_rst", 32'(retire_cnt), 32'd0);
        ctl_WB = mk_ctl(1'b1, 1'b1, 2'b00);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        ctl_WB = '0; #1;
        check("x9_first_edge", dbg_data, 32'h0000_0999);
        check("cnt_first_edge", 32'(retire_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter NREG, default 32, giving the number of architectural registers (x0..x31).
REQ-002 SHALL have parameter CNT_W, default 32, giving the retire counter width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 ctl_WB  input  32  WB control word: bit0 reg_we, bits2:1 wb_sel, bit3 valid; other bits ignored.
REQ-006 ir_WB  input  32  instruction in WB: rd = ir_WB[11:7], funct3 = ir_WB[14:12].
REQ-007 ra_WB  input  32  link value (pc+4) for jal/jalr.
REQ-008 rdata_WB  input  32  raw 32-bit word read from data memory.
REQ-009 alu_y_WB  input  32  ALU result, also the load byte address.
REQ-010 rs1_addr, rs2_addr  input  5 each  ID-stage read addresses.
REQ-011 rs1_data, rs2_data  output  32 each  ID-stage read data.
REQ-012 dbg_addr  input  5  debug read address; dbg_data  output  32  debug read data.
REQ-013 wb_we  output  1  qualified write enable, for forwarding.
REQ-014 wb_rd  output  5  destination register, for forwarding.
REQ-015 wb_data  output  32  selected writeback value, for forwarding.
REQ-016 retire_cnt  output  CNT_W  count of retired instructions.

Function
REQ-017 wb_sel SHALL select: 00 alu_y_WB; 01 extended load data; 10 ra_WB; 11 alu_y_WB.
REQ-018 Load extension SHALL use funct3 and alu_y_WB[1:0]: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; lh/lhu use halfword alu_y_WB[1]; lw ignores the low bits.
REQ-019 Load funct3 011/110/111 SHALL produce rdata_WB unchanged.
REQ-020 wb_we SHALL equal valid & reg_we & (rd != 0); writes to x0 are discarded.
REQ-021 On the rising edge with wb_we=1, regs[rd] SHALL take wb_data; no other register changes.
REQ-022 Read ports SHALL be combinational with write-first bypass: if wb_we and the read address equals wb_rd, the port returns wb_data in the same cycle.
REQ-023 Address 0 on any read port SHALL return 0, regardless of bypass.
REQ-024 dbg_data SHALL apply the same bypass and x0 rules as rs1/rs2.
REQ-025 retire_cnt SHALL increment by 1 per clock with valid=1, independent of reg_we and rd.
REQ-026 retire_cnt SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-027 A bubble (valid=0) SHALL cause no register write, no count, and wb_we=0; wb_data/wb_rd stay combinationally driven.

Reset
REQ-028 While rstn=0, all registers SHALL read 0, retire_cnt SHALL be 0, and no write SHALL occur.
REQ-029 Reset asserted mid-cycle SHALL clear state immediately, without waiting for a clock edge.
REQ-030 On the first edge after rstn rises, a pending valid write SHALL commit normally.

Structure
REQ-031 Ctl bit positions (CTL_REG_WE, CTL_WB_SEL_LO/HI, CTL_VALID), wb_sel encodings, and load funct3 codes SHALL live in the shared pipeline package used by the pipeline registers and the control unit.
REQ-032 Load extension SHALL be a separate combinational sub-module named load_ext (inputs: word, addr[1:0], funct3; output: 32-bit value).
REQ-033 The register array SHALL be NREG-1 flops (x1..x31); x0 SHALL have no storage.

Verification
REQ-034 Reset, then read all 32 addresses -> 0; retire_cnt=0.
REQ-035 valid, reg_we, wb_sel=00, rd=5, alu_y=0x1234_5678; same cycle rs1_addr=5 -> rs1_data=0x1234_5678 (bypass); next cycle still 0x1234_5678 from the array.
REQ-036 rdata=0x8091_A2B3, alu_y low bits=01, funct3=000 -> 0xFFFF_FFA2; funct3=100 -> 0x0000_00A2; alu_y[1]=1, funct3=001 -> 0xFFFF_8091; funct3=101 -> 0x0000_8091.
REQ-037 rd=0 with valid/reg_we, alu_y=0xDEAD_BEEF -> wb_we=0; rs1_addr=0 reads 0; retire_cnt +1.
REQ-038 Bubble (valid=0, reg_we=1, rd=3) -> x3 unchanged and retire_cnt unchanged; counter preset near 2^CNT_W-1 -> wraps to 0 after one more valid.
REQ-039 Assert rstn low mid-cycle after writing x7 -> x7 and retire_cnt read 0 before the next edge.
